euler_result_writeback: RTL and testbench
=========================================

Name: euler_result_writeback

Overview:
- Downstream stage of the Euler step engine. Consumes the (result, address) stream produced at the join stage, qualified by result_stored/result_saved/pc_saved.
- Buffers pairs in a small FIFO and drains them to a single-port state-memory write interface with a valid/ack handshake.
- Reports completion only after the engine has finished and every buffered result has been committed to memory.

Parameters:
- ADD_SIZE, 16, width of write address (matches pc_saved).
- DATA_SIZE, 16, width of write data (matches result_saved).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  new-run pulse; clears sticky done/error.
- result_stored  in  1  push strobe, one pair per cycle when high.
- result_saved  in  DATA_SIZE  result value to write.
- pc_saved  in  ADD_SIZE  destination address.
- euler_finish  in  1  engine finished (level).
- euler_error  in  1  engine overflow/error (level).
- mem_wr_en  out  1  write request valid.
- mem_wr_addr  out  ADD_SIZE  address of FIFO head.
- mem_wr_data  out  DATA_SIZE  data of FIFO head.
- mem_ack  in  1  memory accepted the current request this cycle.
- fifo_count  out  PTR_W+1  occupied entries.
- wb_done  out  1  sticky: all results committed.
- wb_error  out  1  sticky: FIFO overflow or engine error.

Behaviour:
- Reset (rst=1 at posedge): count=0, read/write pointers=0, state=IDLE, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, fifo_count=0, wb_done=0, wb_error=0. Reset wins over every other input. Reset mid-drain discards buffered entries; mem_wr_en is low from the following cycle.
- FSM states:
  - IDLE: entered after reset or after start from DONE/ERROR.
    - result_stored -> RUN.
    - euler_finish with FIFO empty -> DONE.
  - RUN: accepts pushes and drains.
    - euler_finish && count==0 && !result_stored -> DONE.
  - DONE: wb_done=1.
    - A result_stored arriving here still pushes and returns to RUN; wb_done drops.
  - ERROR: wb_error=1, wb_done=0, FIFO flushed (count=0), pushes ignored, mem_wr_en=0.
  - start in DONE or ERROR -> IDLE, clears both flags.
  - euler_error in any state except reset -> ERROR next cycle. This has priority over DONE.
- Push: result_stored at edge t writes {pc_saved, result_saved} at the write pointer. mem_wr_en reflects it from cycle t+1. Latency push->request is 1 cycle.
- Drain:
  - mem_wr_en = (count!=0) and state!=ERROR, driven from registered state.
  - mem_wr_addr/mem_wr_data equal the head entry and are held stable while mem_wr_en && !mem_ack.
  - mem_ack && mem_wr_en at an edge pops the head. mem_ack while mem_wr_en=0 is ignored.
  - Back-to-back pops allowed: one per cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal when full.
- Overflow: push while count==DEPTH with no pop in the same cycle -> entry dropped, state -> ERROR.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- wb_done rises exactly 1 cycle after the edge where euler_finish=1, count==0 and no push are all true.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined: adds output stall_cycles[15:0]. It increments each cycle with mem_wr_en=1 && mem_ack=0, saturates at 16'hFFFF, and clears on rst or start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DONE/ERROR, 2-bit), default widths ADD_SIZE/DATA_SIZE=16.
- One natural sub-module: wb_fifo. It is a synchronous DEPTH-entry FIFO with push/pop/full/empty/count and a head-data output. The FSM, handshake and flags stay in the top.

Test Plan:
- Reset then push addr=16'h0005 data=16'h1234, mem_ack held high -> mem_wr_en high 1 cycle after push with 0005/1234; fifo_count returns to 0; no further request.
- Push 3 pairs on consecutive cycles with mem_ack=0 for 5 cycles -> fifo_count=3; mem_wr_addr/data stable at the first pair; then ack every cycle -> pairs emitted in order, one per cycle.
- Fill to 4 with ack low, then push a 5th -> wb_error=1 next cycle, mem_wr_en=0, fifo_count=0. Push+ack in the same cycle at count=4 -> no error, count stays 4.
- Push 2 pairs, assert euler_finish, ack after 2 cycles -> wb_done stays 0 until the second pop, rises 1 cycle after count hits 0. start -> wb_done=0.
- euler_error while count=2 -> wb_error=1, FIFO flushed. start -> IDLE, both flags 0.
- With WB_STALL_CNT_EN: hold mem_wr_en with ack low for 7 cycles -> stall_cycles=7. start -> 0.

Source files
------------

// File: rtl/euler_result_writeback_pkg.sv
// Shared definitions for the Euler result writeback stage: FSM encoding and default widths.
package euler_result_writeback_pkg;

  localparam int ADD_SIZE_DEF  = 16;
  localparam int DATA_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } wb_state_e;

endpackage

// File: rtl/euler_result_writeback_fifo.sv
// wb_fifo: synchronous DEPTH-entry FIFO with head-data output; storage itself is not reset.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/euler_result_writeback.sv
// Buffers (result, address) pairs and drains them to state memory; optional stall counter via WB_STALL_CNT_EN.
module euler_result_writeback
  import euler_result_writeback_pkg::*;
#(
  parameter int ADD_SIZE  = ADD_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 result_stored,
  input  logic [DATA_SIZE-1:0] result_saved,
  input  logic [ADD_SIZE-1:0]  pc_saved,
  input  logic                 euler_finish,
  input  logic                 euler_error,
  output logic                 mem_wr_en,
  output logic [ADD_SIZE-1:0]  mem_wr_addr,
  output logic [DATA_SIZE-1:0] mem_wr_data,
  input  logic                 mem_ack,
  output logic [PTR_W:0]       fifo_count,
  output logic                 wb_done,
  output logic                 wb_error
`ifdef WB_STALL_CNT_EN
  ,output logic [15:0]         stall_cycles
`endif
);

  localparam int EW = ADD_SIZE + DATA_SIZE;

  wb_state_e       state_q;
  logic            wb_done_q, wb_error_q;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   head;
  logic            pop, overflow, to_error, push_ok, flush;

  assign pop      = mem_wr_en && mem_ack;
  assign overflow = result_stored && (state_q != ST_ERROR) && fifo_full && !pop;
  assign to_error = euler_error || overflow;
  assign push_ok  = result_stored && (state_q != ST_ERROR) && !to_error && (!fifo_full || pop);
  assign flush    = to_error || (state_q == ST_ERROR);

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({pc_saved, result_saved}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wb_done_q  <= 1'b0;
      wb_error_q <= 1'b0;
    end else if (to_error) begin
      state_q    <= ST_ERROR;
      wb_done_q  <= 1'b0;
      wb_error_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (result_stored) begin
            state_q <= ST_RUN;
          end else if (euler_finish && fifo_empty) begin
            state_q   <= ST_DONE;
            wb_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (euler_finish && fifo_empty && !result_stored) begin
            state_q   <= ST_DONE;
            wb_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q   <= ST_IDLE;
            wb_done_q <= 1'b0;
          end else if (result_stored) begin
            state_q   <= ST_RUN;
            wb_done_q <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            state_q    <= ST_IDLE;
            wb_error_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Head is masked when no request is pending so the bus reads zero after reset.
  assign mem_wr_en                  = !fifo_empty && (state_q != ST_ERROR);
  assign {mem_wr_addr, mem_wr_data} = mem_wr_en ? head : '0;
  assign wb_done                    = wb_done_q;
  assign wb_error                   = wb_error_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      stall_q <= '0;
    end else if (mem_wr_en && !mem_ack && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_euler_result_writeback.sv
// Directed self-checking bench for euler_result_writeback; covers WB_STALL_CNT_EN when defined.
module tb_euler_result_writeback;

  logic        clk = 1'b0;
  logic        rst, start, result_stored, euler_finish, euler_error, mem_ack;
  logic [15:0] result_saved, pc_saved;
  logic        mem_wr_en, wb_done, wb_error;
  logic [15:0] mem_wr_addr, mem_wr_data;
  logic [2:0]  fifo_count;
`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  euler_result_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .result_stored (result_stored),
    .result_saved  (result_saved),
    .pc_saved      (pc_saved),
    .euler_finish  (euler_finish),
    .euler_error   (euler_error),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_ack       (mem_ack),
    .fifo_count    (fifo_count),
    .wb_done       (wb_done),
    .wb_error      (wb_error)
`ifdef WB_STALL_CNT_EN
    ,.stall_cycles (stall_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    result_stored = 1'b1;
    pc_saved      = a;
    result_saved  = d;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result_stored = 1'b0; euler_finish = 1'b0;
    euler_error = 1'b0; mem_ack = 1'b0; result_saved = '0; pc_saved = '0;
    step(); step();
    chk("rst_en",    32'(mem_wr_en),   32'd0);
    chk("rst_addr",  32'(mem_wr_addr), 32'd0);
    chk("rst_data",  32'(mem_wr_data), 32'd0);
    chk("rst_count", 32'(fifo_count),  32'd0);
    chk("rst_done",  32'(wb_done),     32'd0);
    chk("rst_err",   32'(wb_error),    32'd0);
    rst = 1'b0;
    step();

    // Single push with ack held high
    mem_ack = 1'b1;
    push(16'h0005, 16'h1234);
    step();
    result_stored = 1'b0;
    chk("t1_en",    32'(mem_wr_en),   32'd1);
    chk("t1_addr",  32'(mem_wr_addr), 32'h0005);
    chk("t1_data",  32'(mem_wr_data), 32'h1234);
    chk("t1_count", 32'(fifo_count),  32'd1);
    step();
    chk("t1_count0", 32'(fifo_count), 32'd0);
    chk("t1_en0",    32'(mem_wr_en),  32'd0);
    step();
    chk("t1_noreq",  32'(mem_wr_en),  32'd0);

    // Three pushes with ack low, then ordered drain
    mem_ack = 1'b0;
    push(16'h0011, 16'hAAAA); step();
    push(16'h0022, 16'hBBBB); step();
    push(16'h0033, 16'hCCCC); step();
    result_stored = 1'b0;
    chk("t2_count3", 32'(fifo_count),  32'd3);
    chk("t2_addrA",  32'(mem_wr_addr), 32'h0011);
    step(); step();
    chk("t2_holdA",  32'(mem_wr_addr), 32'h0011);
    chk("t2_holdD",  32'(mem_wr_data), 32'hAAAA);
    mem_ack = 1'b1;
    step();
    chk("t2_addrB",  32'(mem_wr_addr), 32'h0022);
    chk("t2_dataB",  32'(mem_wr_data), 32'hBBBB);
    step();
    chk("t2_addrC",  32'(mem_wr_addr), 32'h0033);
    chk("t2_dataC",  32'(mem_wr_data), 32'hCCCC);
    step();
    chk("t2_empty",  32'(fifo_count),  32'd0);
    chk("t2_en0",    32'(mem_wr_en),   32'd0);
    mem_ack = 1'b0;

    // Fill, push+pop at full, then overflow
    for (int i = 1; i <= 4; i++) begin
      push(16'(16'h0100 + i), 16'(16'h5000 + i));
      step();
    end
    result_stored = 1'b0;
    chk("t3_full",   32'(fifo_count), 32'd4);
    push(16'h0105, 16'h5005);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t3_pp_cnt",  32'(fifo_count),  32'd4);
    chk("t3_pp_err",  32'(wb_error),    32'd0);
    chk("t3_pp_head", 32'(mem_wr_addr), 32'h0102);
    push(16'h0106, 16'h5006);
    step();
    result_stored = 1'b0;
    chk("t3_ovf_err", 32'(wb_error),   32'd1);
    chk("t3_ovf_en",  32'(mem_wr_en),  32'd0);
    chk("t3_ovf_cnt", 32'(fifo_count), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_clr_err", 32'(wb_error), 32'd0);

    // Completion only after the last pop
    push(16'h0201, 16'h6001); step();
    push(16'h0202, 16'h6002); euler_finish = 1'b1; step();
    result_stored = 1'b0;
    step();
    chk("t4_cnt2",  32'(fifo_count), 32'd2);
    chk("t4_done0", 32'(wb_done),    32'd0);
    step();
    mem_ack = 1'b1;
    step();
    chk("t4_cnt1",  32'(fifo_count), 32'd1);
    chk("t4_done1", 32'(wb_done),    32'd0);
    step();
    mem_ack = 1'b0;
    chk("t4_cnt0",  32'(fifo_count), 32'd0);
    chk("t4_done2", 32'(wb_done),    32'd0);
    step();
    chk("t4_done",  32'(wb_done),    32'd1);
    push(16'h0077, 16'h7777);
    step();
    result_stored = 1'b0;
    chk("t4_rerun_done", 32'(wb_done),    32'd0);
    chk("t4_rerun_cnt",  32'(fifo_count), 32'd1);
    euler_finish = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t4_drained", 32'(fifo_count), 32'd0);
    euler_finish = 1'b1;
    step();
    chk("t4_done_b", 32'(wb_done), 32'd1);
    start = 1'b1; euler_finish = 1'b0;
    step();
    start = 1'b0;
    chk("t4_start", 32'(wb_done), 32'd0);

    // Engine error flushes buffered results
    push(16'h0301, 16'h8001); step();
    push(16'h0302, 16'h8002); step();
    result_stored = 1'b0;
    chk("t5_cnt2", 32'(fifo_count), 32'd2);
    euler_error = 1'b1;
    step();
    euler_error = 1'b0;
    chk("t5_err",   32'(wb_error),   32'd1);
    chk("t5_flush", 32'(fifo_count), 32'd0);
    chk("t5_en",    32'(mem_wr_en),  32'd0);
    push(16'h0303, 16'h8003);
    step();
    result_stored = 1'b0;
    chk("t5_ignore", 32'(fifo_count), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_clr_err",  32'(wb_error), 32'd0);
    chk("t5_clr_done", 32'(wb_done),  32'd0);

`ifdef WB_STALL_CNT_EN
    chk("t6_zero", 32'(stall_cycles), 32'd0);
    push(16'h0401, 16'h9001);
    step();
    result_stored = 1'b0;
    repeat (7) step();
    chk("t6_stall7", 32'(stall_cycles), 32'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_clear", 32'(stall_cycles), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
`endif

    // Reset mid-drain discards entries
    push(16'h0501, 16'hA001); step();
    push(16'h0502, 16'hA002); step();
    result_stored = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_rst_en",  32'(mem_wr_en),  32'd0);
    chk("t7_rst_cnt", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
